// File: rtl/fir_param_mac.sv
// Parametrised direct-form FIR: valid-gated delay line, run-time coefficients,
// full-precision MAC, round-half-up shift and output saturation (latency 2).
module fir_param_mac #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int TAPS   = 10,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       coef_wr,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       sat_flag
);

    // One guard bit above ACC_W so the rounding add can never wrap.
    localparam int XW  = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND  = (SHIFT > 0) ? (XW'(1) << RSH) : '0;
    localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    logic signed [DATA_W-1:0] r_d [TAPS];
    logic signed [COEF_W-1:0] r_h [TAPS];
    logic                     r_v0;
    logic                     r_v1;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [ACC_W-1:0]  w_sum;
    logic signed [XW-1:0]     w_rnd;
    logic signed [XW-1:0]     w_shf;
    logic                     w_hi;
    logic                     w_lo;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_sum = w_sum + ACC_W'(r_d[i]) * ACC_W'(r_h[i]);
        end
    end

    assign w_rnd = XW'(r_acc) + RND;
    assign w_shf = w_rnd >>> SHIFT;
    assign w_hi  = (w_shf > MAXV);
    assign w_lo  = (w_shf < MINV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
        end else if (in_valid) begin
            r_d[0] <= in_data;
            for (int i = 1; i < TAPS; i++) r_d[i] <= r_d[i-1];
        end
    end

    // Coefficients survive clr; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) r_h[i] <= COEF_W'(1);
        end else if (coef_wr && (32'(coef_addr) < TAPS)) begin
            r_h[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            r_v0      <= in_valid & ~clr;
            r_acc     <= w_sum;
            r_v1      <= r_v0 & ~clr;
            out_valid <= r_v1 & ~clr;
            if (r_v1 && !clr) begin
                out_data <= w_hi ? MAXV[OUT_W-1:0] :
                            w_lo ? MINV[OUT_W-1:0] : w_shf[OUT_W-1:0];
                sat_flag <= w_hi | w_lo;
            end
        end
    end

endmodule

// File: tb/tb_fir_param_mac.sv
// Bench for fir_param_mac: table-driven vectors plus hand sequences for clr,
// reset and rounding; outputs are matched against a queue of expected results.
module tb_fir_param_mac;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               in_valid_s;
    logic signed [31:0] in_data;
    logic               coef_wr;
    logic               coef_wr_s;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid, out_valid_s;
    logic signed [31:0] out_data, out_data_s;
    logic               sat_flag, sat_flag_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    logic        sat_q[$];
    int          cyc_q[$];
    logic [31:0] exp_s4_q[$];
    logic        sat_s4_q[$];
    int          cyc_s4_q[$];

    typedef struct {
        logic signed [31:0] din;
        logic signed [31:0] dout;
        logic               sat;
    } vec_t;
    vec_t tbl[40];

    localparam logic signed [31:0] MAX32 = 32'sh7fffffff;
    localparam logic signed [31:0] MIN32 = 32'sh80000000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_param_mac #(.SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag)
    );

    fir_param_mac #(.SHIFT(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_s), .in_data(in_data),
        .coef_wr(coef_wr_s), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid_s), .out_data(out_data_s), .sat_flag(sat_flag_s)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid cyc=%0d data=%0d", cyc, out_data);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic logic        s = sat_q.pop_front();
                automatic int          c = cyc_q.pop_front();
                if (out_data !== e || sat_flag !== s || cyc != c) begin
                    n_fail++;
                    $display("FAIL out_main got data=%0d sat=%0b cyc=%0d want data=%0d sat=%0b cyc=%0d",
                             out_data, sat_flag, cyc, $signed(e), s, c);
                end
            end
        end
        if (rst_n && out_valid_s) begin
            n_checks++;
            if (exp_s4_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid_s4 cyc=%0d data=%0d", cyc, out_data_s);
            end else begin
                automatic logic [31:0] e = exp_s4_q.pop_front();
                automatic logic        s = sat_s4_q.pop_front();
                automatic int          c = cyc_s4_q.pop_front();
                if (out_data_s !== e || sat_flag_s !== s || cyc != c) begin
                    n_fail++;
                    $display("FAIL out_s4 got data=%0d sat=%0b cyc=%0d want data=%0d sat=%0b cyc=%0d",
                             out_data_s, sat_flag_s, cyc, $signed(e), s, c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic ivs, input logic signed [31:0] d,
                        input logic cw, input logic cws, input logic [3:0] ca,
                        input logic signed [15:0] cd, input logic c);
        @(posedge clk);
        #1;
        in_valid = iv; in_valid_s = ivs; in_data = d;
        coef_wr = cw; coef_wr_s = cws; coef_addr = ca; coef_data = cd; clr = c;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b0);
    endtask

    task automatic smp(input logic signed [31:0] d, input logic push,
                       input logic signed [31:0] e, input logic s);
        step(1'b1, 1'b0, d, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b0);
        if (push) begin
            exp_q.push_back(e); sat_q.push_back(s); cyc_q.push_back(cyc + 3);
        end
    endtask

    task automatic smp_s4(input logic signed [31:0] d, input logic signed [31:0] e);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b0);
        exp_s4_q.push_back(e); sat_s4_q.push_back(1'b0); cyc_s4_q.push_back(cyc + 3);
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [15:0] v);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, a, v, 1'b0);
    endtask

    task automatic wr_s4(input logic [3:0] a, input logic signed [15:0] v);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, a, v, 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp_s4_q.size() != 0) && n < 30) begin
            idle();
            n++;
        end
        idle();
        chk(name, 64'(exp_q.size() + exp_s4_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 10; i++) tbl[i]      = '{32'sd1, 32'(i + 1), 1'b0};
        for (int i = 0; i < 10; i++) tbl[10 + i] = '{32'sd2, 32'(11 + i), 1'b0};
        for (int i = 0; i < 10; i++) tbl[20 + i] = '{MAX32, MAX32, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (i < 4)       tbl[30 + i] = '{MIN32, MAX32, 1'b1};
            else if (i == 4) tbl[30 + i] = '{MIN32, -32'sd163835, 1'b0};
            else             tbl[30 + i] = '{MIN32, MIN32, 1'b1};
        end

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0; in_data = '0;
        coef_wr = 1'b0; coef_wr_s = 1'b0; coef_addr = '0; coef_data = '0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_sat_flag", 64'(sat_flag), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Default moving sum, then a second plateau
        for (int i = 0; i < 20; i++) smp(tbl[i].din, 1'b1, tbl[i].dout, tbl[i].sat);
        drain("drain_t1_t2");
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("gap_no_valid", 64'(out_valid), 64'd0);
            chk("gap_hold_data", 64'(out_data), 64'd20);
        end

        // Single-tap gain with an ignored out-of-range write
        wr(4'd0, 16'sd3);
        for (int i = 1; i < 10; i++) wr(4'(i), 16'sd0);
        wr(4'd12, 16'sd99);
        flush();
        smp(32'sd5, 1'b1, 32'sd15, 1'b0);
        smp(32'sd0, 1'b1, 32'sd0, 1'b0);
        smp(32'sd0, 1'b1, 32'sd0, 1'b0);
        drain("drain_t3");

        // Saturation at both rails and the unsaturated crossover
        for (int i = 0; i < 10; i++) wr(4'(i), 16'sd32767);
        for (int i = 20; i < 40; i++) smp(tbl[i].din, 1'b1, tbl[i].dout, tbl[i].sat);
        drain("drain_t4");
        chk("sat_hold_after", 64'(sat_flag), 64'd1);

        // clr drops in-flight samples and the sample presented with it
        for (int i = 0; i < 10; i++) wr(4'(i), 16'sd1);
        flush();
        smp(32'sd1, 1'b1, 32'sd1, 1'b0);
        smp(32'sd2, 1'b0, 0, 1'b0);
        smp(32'sd3, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 32'sd99, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
        smp(32'sd7, 1'b1, 32'sd7, 1'b0);
        smp(32'sd9, 1'b1, 32'sd16, 1'b0);
        smp(32'sd11, 1'b0, 0, 1'b0);
        idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_data", 64'(out_data), 64'd0);
        idle();
        idle();
        rst_n = 1'b1;
        smp(32'sd4, 1'b1, 32'sd4, 1'b0);
        drain("drain_t6");

        // Rounding shift on the SHIFT=4 instance
        for (int i = 1; i < 10; i++) wr_s4(4'(i), 16'sd0);
        smp_s4(32'sd24, 32'sd2);
        smp_s4(-32'sd24, -32'sd1);
        smp_s4(32'sd8, 32'sd1);
        smp_s4(-32'sd8, 32'sd0);
        smp_s4(32'sd40, 32'sd3);
        drain("drain_t5");
        chk("main_idle_during_s4", 64'(out_data), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
